demux_1to4_stream: RTL and testbench

DEMUX_1TO4_STREAM -- requirements
Module: demux_1to4_stream

---
 rtl/demux_1to4_stream.sv | 134 +++++++++++++
 tb/tb_demux_1to4_stream.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/demux_1to4_stream.sv
// 1-to-4 stream demultiplexer: packets are routed by s_sel on their first beat
// and stay locked to that channel until s_last. Define DEMUX_BEAT_COUNT_EN to build
// saturating per-channel delivered-beat counters.
module demux_1to4_stream #(
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_W-1:0]     s_data,
  input  logic                  s_last,
  input  logic [1:0]            s_sel,
  output logic [3:0]            m_valid,
  input  logic [3:0]            m_ready,
  output logic [4*DATA_W-1:0]   m_data,
  output logic [3:0]            m_last,
  output logic [63:0]           beat_cnt
);

  typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_e;

  state_e                   state_q, state_d;
  logic [1:0]               lock_ch_q, lock_ch_d;
  logic [3:0]               valid_q, valid_d;
  logic [3:0]               last_q, last_d;
  logic [3:0][DATA_W-1:0]   data_q, data_d;
  logic [1:0]               tgt_s;
  logic                     accept_s;
  logic [3:0]               deliver_s;

  // Target selection and handshakes; s_ready is forced low while reset is held.
  always_comb begin
    tgt_s     = (state_q == LOCK) ? lock_ch_q : s_sel;
    s_ready   = rst_n & (~valid_q[tgt_s] | m_ready[tgt_s]);
    accept_s  = s_valid & s_ready;
    deliver_s = valid_q & m_ready;
  end

  // Packet lock FSM next state.
  always_comb begin
    state_d   = state_q;
    lock_ch_d = lock_ch_q;
    case (state_q)
      IDLE: begin
        if (accept_s && !s_last) begin
          state_d   = LOCK;
          lock_ch_d = tgt_s;
        end else begin
          state_d = IDLE;
        end
      end
      LOCK: begin
        if (accept_s && s_last) begin
          state_d = IDLE;
        end else begin
          state_d = LOCK;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // One output slot per channel; a load in the same cycle as a delivery replaces the slot.
  always_comb begin
    valid_d = valid_q;
    last_d  = last_q;
    data_d  = data_q;
    for (int i = 0; i < 4; i++) begin
      if (accept_s && (tgt_s == 2'(i))) begin
        valid_d[i] = 1'b1;
        last_d[i]  = s_last;
        data_d[i]  = s_data;
      end else if (deliver_s[i]) begin
        valid_d[i] = 1'b0;
      end else begin
        valid_d[i] = valid_q[i];
      end
    end
  end

  // State and slot registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      lock_ch_q <= 2'd0;
      valid_q   <= 4'd0;
      last_q    <= 4'd0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      lock_ch_q <= lock_ch_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      data_q    <= data_d;
    end
  end

  assign m_valid = valid_q;
  assign m_last  = last_q;
  assign m_data  = data_q;

`ifdef DEMUX_BEAT_COUNT_EN
  logic [3:0][15:0] cnt_q, cnt_d;

  // Saturating delivered-beat counters.
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < 4; i++) begin
      if (deliver_s[i] && (cnt_q[i] != 16'hFFFF)) begin
        cnt_d[i] = cnt_q[i] + 16'd1;
      end else begin
        cnt_d[i] = cnt_q[i];
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign beat_cnt = cnt_q;
`else
  assign beat_cnt = 64'd0;
`endif

endmodule

// File: tb/tb_demux_1to4_stream.sv
// Table-driven bench for demux_1to4_stream with hand-written reset and counter sequences.
module tb_demux_1to4_stream;

  logic        clk;
  logic        rst_n;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        s_last;
  logic [1:0]  s_sel;
  logic [3:0]  m_valid;
  logic [3:0]  m_ready;
  logic [31:0] m_data;
  logic [3:0]  m_last;
  logic [63:0] beat_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rst_n;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_last;
    logic [1:0]  s_sel;
    logic [3:0]  m_ready;
    logic        exp_ready;
    logic [3:0]  exp_valid;
    logic [31:0] exp_data;
    logic [3:0]  exp_last;
  } vec_t;

  vec_t vecs[$];
  logic [3:0]       exp_valid_prev = 4'd0;
  logic [3:0][15:0] cnt_model = '0;

  demux_1to4_stream #(.DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last), .s_sel(s_sel), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .beat_cnt(beat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic r, logic v, logic [7:0] d, logic l, logic [1:0] sel,
                              logic [3:0] rdy, logic er, logic [3:0] ev, logic [31:0] ed,
                              logic [3:0] el);
    vec_t x;
    x.rst_n = r; x.s_valid = v; x.s_data = d; x.s_last = l; x.s_sel = sel;
    x.m_ready = rdy; x.exp_ready = er; x.exp_valid = ev; x.exp_data = ed; x.exp_last = el;
    return x;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input vec_t v, input int idx);
    logic [31:0] mask;
    logic [63:0] exp_cnt;
    rst_n = v.rst_n; s_valid = v.s_valid; s_data = v.s_data;
    s_last = v.s_last; s_sel = v.s_sel; m_ready = v.m_ready;
    #1;
    chk($sformatf("s_ready[%0d]", idx), {63'd0, s_ready}, {63'd0, v.exp_ready});
    if (!v.rst_n) begin
      cnt_model = '0;
    end else begin
      for (int i = 0; i < 4; i++)
        if (exp_valid_prev[i] && v.m_ready[i] && cnt_model[i] != 16'hFFFF)
          cnt_model[i] = cnt_model[i] + 16'd1;
    end
    exp_valid_prev = v.exp_valid;
    @(posedge clk);
    #1;
    mask = '0;
    for (int i = 0; i < 4; i++) if (v.exp_valid[i]) mask[i*8 +: 8] = 8'hFF;
    chk($sformatf("m_valid[%0d]", idx), {60'd0, m_valid}, {60'd0, v.exp_valid});
    chk($sformatf("m_last[%0d]", idx), {60'd0, m_last & v.exp_valid}, {60'd0, v.exp_last});
    chk($sformatf("m_data[%0d]", idx), {32'd0, m_data & mask}, {32'd0, v.exp_data & mask});
`ifdef DEMUX_BEAT_COUNT_EN
    exp_cnt = cnt_model;
`else
    exp_cnt = 64'd0;
`endif
    chk($sformatf("beat_cnt[%0d]", idx), beat_cnt, exp_cnt);
  endtask

  initial begin
    // reset
    vecs.push_back(mk(1'b0, 1'b1, 8'h00, 1'b0, 2'd0, 4'hF, 1'b0, 4'h0, 32'h0, 4'h0));
    // single beat to ch2
    vecs.push_back(mk(1'b1, 1'b1, 8'hA5, 1'b1, 2'd2, 4'hF, 1'b1, 4'h4, 32'h00A50000, 4'h4));
    vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 4'hF, 1'b1, 4'h0, 32'h0, 4'h0));
    // packet lock on ch1
    vecs.push_back(mk(1'b1, 1'b1, 8'h11, 1'b0, 2'd1, 4'hF, 1'b1, 4'h2, 32'h00001100, 4'h0));
    vecs.push_back(mk(1'b1, 1'b1, 8'h22, 1'b0, 2'd3, 4'hF, 1'b1, 4'h2, 32'h00002200, 4'h0));
    vecs.push_back(mk(1'b1, 1'b1, 8'h33, 1'b1, 2'd0, 4'hF, 1'b1, 4'h2, 32'h00003300, 4'h2));
    vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 4'hF, 1'b1, 4'h0, 32'h0, 4'h0));
    // backpressure on ch0
    vecs.push_back(mk(1'b1, 1'b1, 8'h44, 1'b1, 2'd0, 4'hE, 1'b1, 4'h1, 32'h00000044, 4'h1));
    vecs.push_back(mk(1'b1, 1'b1, 8'h55, 1'b0, 2'd0, 4'hE, 1'b0, 4'h1, 32'h00000044, 4'h1));
    vecs.push_back(mk(1'b1, 1'b1, 8'h66, 1'b1, 2'd3, 4'hE, 1'b1, 4'h9, 32'h66000044, 4'h9));
    vecs.push_back(mk(1'b1, 1'b1, 8'h55, 1'b0, 2'd0, 4'h6, 1'b0, 4'h9, 32'h66000044, 4'h9));
    vecs.push_back(mk(1'b1, 1'b1, 8'h55, 1'b0, 2'd0, 4'hF, 1'b1, 4'h1, 32'h00000055, 4'h0));
    vecs.push_back(mk(1'b1, 1'b1, 8'h77, 1'b1, 2'd2, 4'hF, 1'b1, 4'h1, 32'h00000077, 4'h1));
    vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 4'hF, 1'b1, 4'h0, 32'h0, 4'h0));
    // full throughput: 8 back-to-back beats locked to ch1
    for (int i = 0; i < 8; i++) begin
      logic [7:0] d;
      logic [1:0] sel;
      d   = 8'hC0 + 8'(i);
      sel = (i == 0) ? 2'd1 : 2'(3 - (i % 4));
      vecs.push_back(mk(1'b1, 1'b1, d, (i == 7), sel, 4'hF, 1'b1, 4'h2,
                        {16'h0, d, 8'h0}, (i == 7) ? 4'h2 : 4'h0));
    end
    vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 4'hF, 1'b1, 4'h0, 32'h0, 4'h0));

    for (int k = 0; k < vecs.size(); k++) step(vecs[k], k);

    // reset mid-packet: two beats of a 4-beat packet on ch2, then reset
    step(mk(1'b1, 1'b1, 8'h01, 1'b0, 2'd2, 4'hF, 1'b1, 4'h4, 32'h00010000, 4'h0), 100);
    step(mk(1'b1, 1'b1, 8'h02, 1'b0, 2'd0, 4'hF, 1'b1, 4'h4, 32'h00020000, 4'h0), 101);
    step(mk(1'b0, 1'b1, 8'h03, 1'b0, 2'd0, 4'hF, 1'b0, 4'h0, 32'h0, 4'h0), 102);
    chk("reset_m_data", {32'd0, m_data}, 64'd0);
    chk("reset_m_last", {60'd0, m_last}, 64'd0);
    step(mk(1'b1, 1'b1, 8'h9A, 1'b1, 2'd0, 4'hF, 1'b1, 4'h1, 32'h0000009A, 4'h1), 103);
    step(mk(1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 4'hF, 1'b1, 4'h0, 32'h0, 4'h0), 104);

`ifdef DEMUX_BEAT_COUNT_EN
    // saturation: stream single-beat packets to ch3 past 65535 deliveries
    rst_n = 1'b0; s_valid = 1'b0; m_ready = 4'hF;
    @(posedge clk); #1;
    rst_n = 1'b1; s_valid = 1'b1; s_sel = 2'd3; s_last = 1'b1; s_data = 8'h3C;
    for (int n = 0; n < 65538; n++) begin
      @(posedge clk); #1;
      if (n == 65535) chk("beat_cnt_ch3_pre_sat", {48'd0, beat_cnt[63:48]}, 64'h0000_0000_0000_FFFF);
    end
    s_valid = 1'b0;
    @(posedge clk); #1;
    chk("beat_cnt_ch3_sat", {48'd0, beat_cnt[63:48]}, 64'h0000_0000_0000_FFFF);
    chk("beat_cnt_ch0_idle", {48'd0, beat_cnt[15:0]}, 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
